// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding,
// default widths and helpers for derived widths.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned DEF_PROD_W = 8;
  localparam int unsigned DEF_ACC_W  = 12;
  localparam int unsigned DEF_COUNT  = 4;

  // Largest value the accumulator can hold at the default width.
  localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

  // Frame counter must reach COUNT, so it needs room for COUNT itself.
  function automatic int unsigned cnt_width(input int unsigned count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned saturating adder: accumulator plus zero-extended product,
// clamped to all-ones when the sum no longer fits in ACC_W bits.
module sat_adder #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [PROD_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W:0] full;

  // One extra bit catches the carry out; carry set means clamp.
  always_comb begin
    full  = {1'b0, a_i} + SUM_W'(b_i);
    ovf_o = full[ACC_W];
    sum_o = ovf_o ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of COUNT unsigned products with saturation and presents
// the result on a valid/ready port until the consumer takes it.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned COUNT  = DEF_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum_data,
  output logic              sum_sat,
  output logic              busy
);

  localparam int unsigned         CNT_W    = cnt_width(COUNT);
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(COUNT - 1);

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("ACC_W must be >= PROD_W");
  end
  if (COUNT < 1 || COUNT > 15) begin : g_bad_count
    $error("COUNT must be in 1..15");
  end

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  logic             accept;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_adder (
    .a_i   (acc_q),
    .b_i   (prod_data),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  assign prod_ready = (state_q != HOLD);
  assign accept     = prod_valid && prod_ready;
  assign sum_valid  = (state_q == HOLD);
  assign busy       = (state_q == ACC);
  assign sum_data   = acc_q;
  assign sum_sat    = sat_q;

  // Frame FSM: first product loads, later ones add, HOLD waits for the take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q   <= ACC_W'(prod_data);
            cnt_q   <= CNT_W'(1);
            sat_q   <= 1'b0;
            state_q <= (COUNT == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_q <= add_sum;
            cnt_q <= cnt_q + CNT_W'(1);
            sat_q <= sat_q | add_ovf;
            if (cnt_q == LAST_CNT) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: two accumulators (12-bit and 9-bit result) share one
// stimulus stream; a frame-level model predicts results and handshakes.
module tb_product_accumulator;

  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       prod_valid = 1'b0;
  logic       sum_ready = 1'b0;
  logic [7:0] prod_data = '0;

  logic        pr12, sv12, ss12, bz12;
  logic [11:0] sd12;
  logic        pr9, sv9, ss9, bz9;
  logic [8:0]  sd9;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(8), .ACC_W(12), .COUNT(COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(pr12), .prod_data(prod_data),
    .sum_valid(sv12), .sum_ready(sum_ready), .sum_data(sd12),
    .sum_sat(ss12), .busy(bz12)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(COUNT)) dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(pr9), .prod_data(prod_data),
    .sum_valid(sv9), .sum_ready(sum_ready), .sum_data(sd9),
    .sum_sat(ss9), .busy(bz9)
  );

  typedef struct {
    int data;
    int sat;
  } exp_t;

  exp_t q12[$];
  exp_t q9[$];

  int n_chk = 0;
  int n_fail = 0;

  // Frame model: products seen so far, their plain sum, result pending flag.
  int m_cnt = 0;
  int m_sum = 0;
  bit m_pend = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict(input int total, input int w);
    exp_t e;
    int mx;
    mx = (1 << w) - 1;
    e.data = (total > mx) ? mx : total;
    e.sat  = (total > mx) ? 1 : 0;
    return e;
  endfunction

  // Model reset: everything in flight is lost.
  always @(negedge rst_n) begin
    m_cnt = 0;
    m_sum = 0;
    m_pend = 1'b0;
    q12.delete();
    q9.delete();
  end

  // Model update at each active edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    if (rst_n) begin
      if (clear) begin
        m_cnt = 0;
        m_sum = 0;
        if (m_pend) begin
          if (q12.size() > 0) void'(q12.pop_front());
          if (q9.size() > 0) void'(q9.pop_front());
        end
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (sum_ready) m_pend = 1'b0;
      end else if (prod_valid) begin
        m_sum += int'(prod_data);
        m_cnt++;
        if (m_cnt == COUNT) begin
          q12.push_back(predict(m_sum, 12));
          q9.push_back(predict(m_sum, 9));
          m_pend = 1'b1;
          m_cnt = 0;
          m_sum = 0;
        end
      end
    end
  end

  // Monitor: handshake outputs every cycle, results whenever presented.
  always @(negedge clk) begin
    chk("prod_ready12", int'(pr12), int'(!m_pend));
    chk("prod_ready9", int'(pr9), int'(!m_pend));
    chk("sum_valid12", int'(sv12), int'(m_pend));
    chk("sum_valid9", int'(sv9), int'(m_pend));
    chk("busy12", int'(bz12), int'(m_cnt > 0 && !m_pend));
    chk("busy9", int'(bz9), int'(m_cnt > 0 && !m_pend));
    if (sv12) begin
      if (q12.size() == 0) chk("result12_expected", 0, 1);
      else begin
        chk("sum_data12", int'(sd12), q12[0].data);
        chk("sum_sat12", int'(ss12), q12[0].sat);
        if (sum_ready && !clear && rst_n) void'(q12.pop_front());
      end
    end
    if (sv9) begin
      if (q9.size() == 0) chk("result9_expected", 0, 1);
      else begin
        chk("sum_data9", int'(sd9), q9[0].data);
        chk("sum_sat9", int'(ss9), q9[0].sat);
        if (sum_ready && !clear && rst_n) void'(q9.pop_front());
      end
    end
  end

  task automatic step(input bit v, input int d, input bit r, input bit c);
    prod_valid = v;
    prod_data  = 8'(d);
    sum_ready  = r;
    clear      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic frame4(input int a, input int b, input int c, input int d,
                        input bit r);
    step(1'b1, a, r, 1'b0);
    step(1'b1, b, r, 1'b0);
    step(1'b1, c, r, 1'b0);
    step(1'b1, d, r, 1'b0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 0, r, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, taken immediately.
    frame4(12, 35, 81, 225, 1'b1);
    idle(2, 1'b1);

    // Backpressure: result held, extra products refused.
    frame4(12, 35, 81, 225, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 99, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Gapped input.
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, k, 1'b1, 1'b0);
      if (k < 4) idle(2, 1'b1);
    end
    idle(2, 1'b1);

    // Saturation on the 9-bit instance, then a clean small frame.
    frame4(225, 225, 225, 225, 1'b1);
    idle(2, 1'b1);
    frame4(1, 1, 1, 1, 1'b1);
    idle(2, 1'b1);

    // Clear mid-frame drops the concurrent product.
    step(1'b1, 50, 1'b1, 1'b0);
    step(1'b1, 60, 1'b1, 1'b0);
    step(1'b1, 70, 1'b1, 1'b1);
    frame4(5, 5, 5, 5, 1'b1);
    idle(2, 1'b1);

    // Clear in HOLD discards the pending result.
    frame4(7, 7, 7, 7, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 70, int'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
    end
    idle(8, 1'b1);

    // Asynchronous reset mid-frame: outputs drop without a clock edge.
    step(1'b1, 40, 1'b1, 1'b0);
    step(1'b1, 41, 1'b1, 1'b0);
    prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sum_valid12", int'(sv12), 0);
    chk("rst_sum_data12", int'(sd12), 0);
    chk("rst_sum_sat12", int'(ss12), 0);
    chk("rst_busy12", int'(bz12), 0);
    chk("rst_prod_ready12", int'(pr12), 1);
    chk("rst_busy9", int'(bz9), 0);
    chk("rst_sum_data9", int'(sd9), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame4(3, 4, 5, 6, 1'b1);
    idle(8, 1'b1);

    chk("queue12_drained", q12.size(), 0);
    chk("queue9_drained", q9.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
